// File: rtl/synth_vga_pkg.sv
// Shared definitions for the keyboard-highlight path: note encoding, on-screen
// key geometry, key colouring and the highlight sequencer state encoding.
package synth_vga_pkg;

    localparam int unsigned NOTE_W   = 4;
    localparam int unsigned X_W      = 9;
    localparam int unsigned Y_W      = 8;
    localparam int unsigned COLOUR_W = 3;

    // Any code above NOTE_MAX (or a silent note) collapses to NOTE_NONE.
    localparam logic [NOTE_W-1:0] NOTE_NONE = 4'hF;
    localparam logic [NOTE_W-1:0] NOTE_MAX  = 4'd11;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ERASE_REQ  = 3'd1,
        ST_ERASE_WAIT = 3'd2,
        ST_DRAW_REQ   = 3'd3,
        ST_DRAW_WAIT  = 3'd4
    } hl_state_t;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } key_pos_t;

    // Top-left corner of the highlight box for each note, C..B.
    function automatic key_pos_t key_pos(input logic [NOTE_W-1:0] note);
        key_pos_t p;
        case (note)
            4'd0:    p = '{x: 9'd33,  y: 8'd57};
            4'd1:    p = '{x: 9'd40,  y: 8'd44};
            4'd2:    p = '{x: 9'd49,  y: 8'd57};
            4'd3:    p = '{x: 9'd57,  y: 8'd44};
            4'd4:    p = '{x: 9'd64,  y: 8'd57};
            4'd5:    p = '{x: 9'd80,  y: 8'd57};
            4'd6:    p = '{x: 9'd87,  y: 8'd44};
            4'd7:    p = '{x: 9'd96,  y: 8'd57};
            4'd8:    p = '{x: 9'd104, y: 8'd44};
            4'd9:    p = '{x: 9'd112, y: 8'd57};
            4'd10:   p = '{x: 9'd121, y: 8'd44};
            4'd11:   p = '{x: 9'd128, y: 8'd57};
            default: p = '{x: 9'd0,   y: 8'd0};
        endcase
        return p;
    endfunction

    // Sharps/flats sit in the upper (black-key) row.
    function automatic logic is_black_key(input logic [NOTE_W-1:0] note);
        logic black;
        case (note)
            4'd1, 4'd3, 4'd6, 4'd8, 4'd10: black = 1'b1;
            default:                       black = 1'b0;
        endcase
        return black;
    endfunction

endpackage

// File: rtl/note_settle_filter.sv
// Glitch filter for the requested highlight note. The raw target is the note
// when it is sounding and in range, otherwise NOTE_NONE; it is only passed on
// once it has held the same value for SETTLE_CYCLES consecutive cycles.
//   clk, rst       : clock, synchronous active-high reset
//   note, note_on  : raw note code and sounding flag from the synth
//   stable_tgt     : settled target note (NOTE_NONE after reset)
module note_settle_filter
    import synth_vga_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NOTE_W-1:0] note,
    input  logic              note_on,
    output logic [NOTE_W-1:0] stable_tgt
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [NOTE_W-1:0] target_c;
    logic [NOTE_W-1:0] prev_tgt;
    logic [CNT_W-1:0]  cnt;

    // Out-of-range codes and silence both mean "no highlight".
    assign target_c = (note_on && (note <= NOTE_MAX)) ? note : NOTE_NONE;

    // Counter restarts on any change and parks at its last value once settled.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_tgt   <= NOTE_NONE;
            cnt        <= '0;
            stable_tgt <= NOTE_NONE;
        end else if (target_c != prev_tgt) begin
            prev_tgt <= target_c;
            cnt      <= '0;
        end else if (cnt == CNT_LAST) begin
            stable_tgt <= prev_tgt;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/note_highlight_ctrl.sv
// Keyboard-highlight sequencer. On each settled change of the target note it
// asks the box drawer to repaint the old highlight in its key colour, then to
// paint the new one, over a start/done handshake with a timeout.
//   iClock, iReset : clock, synchronous active-high reset
//   iNote, iNoteOn : current synth note (0-11 valid) and sounding flag
//   iDrawDone      : one-cycle completion pulse from the box drawer
//   oStart         : one-cycle draw request
//   oX, oY, oColour: box position and colour, held until the matching done
//   oBusy          : sequencer not idle
//   oActiveNote    : note currently highlighted on screen
//   oActiveValid   : a highlight is on screen
//   oTimeout       : sticky handshake-timeout flag
module note_highlight_ctrl
    import synth_vga_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter logic [2:0]  HILITE_COLOUR  = 3'b110,
    parameter logic [2:0]  WHITE_COLOUR   = 3'b111,
    parameter logic [2:0]  BLACK_COLOUR   = 3'b000,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                iClock,
    input  logic                iReset,
    input  logic [NOTE_W-1:0]   iNote,
    input  logic                iNoteOn,
    input  logic                iDrawDone,
    output logic                oStart,
    output logic [X_W-1:0]      oX,
    output logic [Y_W-1:0]      oY,
    output logic [COLOUR_W-1:0] oColour,
    output logic                oBusy,
    output logic [NOTE_W-1:0]   oActiveNote,
    output logic                oActiveValid,
    output logic                oTimeout
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    hl_state_t state, state_nxt;

    logic [NOTE_W-1:0]   stable_tgt;
    logic [NOTE_W-1:0]   pending;
    logic [TO_W-1:0]     tcnt;

    logic [NOTE_W-1:0]   pending_nxt;
    logic [TO_W-1:0]     tcnt_nxt;
    logic                start_nxt;
    logic [X_W-1:0]      x_nxt;
    logic [Y_W-1:0]      y_nxt;
    logic [COLOUR_W-1:0] colour_nxt;
    logic                busy_nxt;
    logic [NOTE_W-1:0]   active_note_nxt;
    logic                active_valid_nxt;
    logic                timeout_nxt;

    logic [NOTE_W-1:0]   displayed_c;
    key_pos_t            erase_pos_c;
    key_pos_t            draw_pos_c;
    logic                wait_expired_c;

    note_settle_filter #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle (
        .clk        (iClock),
        .rst        (iReset),
        .note       (iNote),
        .note_on    (iNoteOn),
        .stable_tgt (stable_tgt)
    );

    assign displayed_c    = oActiveValid ? oActiveNote : NOTE_NONE;
    assign erase_pos_c    = key_pos(oActiveNote);
    assign draw_pos_c     = key_pos(stable_tgt);
    assign wait_expired_c = (tcnt == TO_LAST);

    // State register and registered outputs.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state        <= ST_IDLE;
            pending      <= '0;
            tcnt         <= '0;
            oStart       <= 1'b0;
            oX           <= '0;
            oY           <= '0;
            oColour      <= '0;
            oBusy        <= 1'b0;
            oActiveNote  <= '0;
            oActiveValid <= 1'b0;
            oTimeout     <= 1'b0;
        end else begin
            state        <= state_nxt;
            pending      <= pending_nxt;
            tcnt         <= tcnt_nxt;
            oStart       <= start_nxt;
            oX           <= x_nxt;
            oY           <= y_nxt;
            oColour      <= colour_nxt;
            oBusy        <= busy_nxt;
            oActiveNote  <= active_note_nxt;
            oActiveValid <= active_valid_nxt;
            oTimeout     <= timeout_nxt;
        end
    end

    // Next-state and next-output logic. Box coordinates are loaded only on
    // entry to a REQ state so they stay put until the drawer finishes.
    always_comb begin
        state_nxt        = state;
        pending_nxt      = pending;
        tcnt_nxt         = '0;
        x_nxt            = oX;
        y_nxt            = oY;
        colour_nxt       = oColour;
        active_note_nxt  = oActiveNote;
        active_valid_nxt = oActiveValid;
        timeout_nxt      = oTimeout;

        case (state)
            ST_IDLE: begin
                if (stable_tgt != displayed_c) begin
                    if (oActiveValid) begin
                        state_nxt  = ST_ERASE_REQ;
                        x_nxt      = erase_pos_c.x;
                        y_nxt      = erase_pos_c.y;
                        colour_nxt = is_black_key(oActiveNote) ? BLACK_COLOUR : WHITE_COLOUR;
                    end else if (stable_tgt != NOTE_NONE) begin
                        state_nxt   = ST_DRAW_REQ;
                        pending_nxt = stable_tgt;
                        x_nxt       = draw_pos_c.x;
                        y_nxt       = draw_pos_c.y;
                        colour_nxt  = HILITE_COLOUR;
                    end
                end
            end

            ST_ERASE_REQ: state_nxt = ST_ERASE_WAIT;

            ST_ERASE_WAIT: begin
                if (iDrawDone) begin
                    active_valid_nxt = 1'b0;
                    if (stable_tgt != NOTE_NONE) begin
                        state_nxt   = ST_DRAW_REQ;
                        pending_nxt = stable_tgt;
                        x_nxt       = draw_pos_c.x;
                        y_nxt       = draw_pos_c.y;
                        colour_nxt  = HILITE_COLOUR;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (wait_expired_c) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = ST_IDLE;
                end else begin
                    tcnt_nxt = tcnt + TO_W'(1);
                end
            end

            ST_DRAW_REQ: state_nxt = ST_DRAW_WAIT;

            ST_DRAW_WAIT: begin
                if (iDrawDone) begin
                    active_note_nxt  = pending;
                    active_valid_nxt = 1'b1;
                    state_nxt        = ST_IDLE;
                end else if (wait_expired_c) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = ST_IDLE;
                end else begin
                    tcnt_nxt = tcnt + TO_W'(1);
                end
            end

            default: state_nxt = ST_IDLE;
        endcase

        // Request and busy flags mirror the state being entered.
        start_nxt = (state_nxt == ST_ERASE_REQ) || (state_nxt == ST_DRAW_REQ);
        busy_nxt  = (state_nxt != ST_IDLE);
    end

endmodule

// File: tb/tb_note_highlight_ctrl.sv
// Directed bench for note_highlight_ctrl with the default parameters.
module tb_note_highlight_ctrl;

    logic       iClock = 1'b0;
    logic       iReset;
    logic [3:0] iNote;
    logic       iNoteOn;
    logic       iDrawDone;
    logic       oStart;
    logic [8:0] oX;
    logic [7:0] oY;
    logic [2:0] oColour;
    logic       oBusy;
    logic [3:0] oActiveNote;
    logic       oActiveValid;
    logic       oTimeout;

    int vectors = 0;
    int miscompares = 0;

    // A fresh target set just after a falling edge raises oStart on the 18th
    // rising edge: 17 edges to settle (cycles 0..16), request in cycle 17.
    localparam int REQ_TICKS = 18;

    note_highlight_ctrl dut (
        .iClock       (iClock),
        .iReset       (iReset),
        .iNote        (iNote),
        .iNoteOn      (iNoteOn),
        .iDrawDone    (iDrawDone),
        .oStart       (oStart),
        .oX           (oX),
        .oY           (oY),
        .oColour      (oColour),
        .oBusy        (oBusy),
        .oActiveNote  (oActiveNote),
        .oActiveValid (oActiveValid),
        .oTimeout     (oTimeout)
    );

    always #5 iClock = ~iClock;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge iClock);
        @(negedge iClock);
    endtask

    task automatic pulse_done();
        iDrawDone = 1'b1;
        tick();
        iDrawDone = 1'b0;
    endtask

    // Bounded wait for a request; n = edges taken, -1 if none arrived.
    task automatic wait_start(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (oStart === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        iReset = 1'b1; iNote = 4'd0; iNoteOn = 1'b0; iDrawDone = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({oStart, oX, oY, oColour, oBusy, oActiveNote, oActiveValid, oTimeout} !== 28'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got start=%b x=%0d y=%0d col=%b busy=%b note=%0d valid=%b to=%b, want all 0",
                     oStart, oX, oY, oColour, oBusy, oActiveNote, oActiveValid, oTimeout);
        end
        iReset = 1'b0;
        tick();
        pulse_done();
        vectors++;
        if ({oBusy, oActiveValid, oStart} !== 3'b000) begin
            miscompares++;
            $display("FAIL idle_done_ignored: busy=%b valid=%b start=%b, want 000", oBusy, oActiveValid, oStart);
        end
    endtask

    task automatic test_first_draw();
        bit early = 1'b0;
        iNoteOn = 1'b1; iNote = 4'd4;
        for (int i = 0; i < 17; i++) begin
            tick();
            if (oStart === 1'b1) early = 1'b1;
        end
        vectors++;
        if (early !== 1'b0) begin
            miscompares++;
            $display("FAIL first_early_start: oStart before cycle 17, want none");
        end
        tick();
        vectors++;
        if ({oStart, oX, oY, oColour, oBusy} !== {1'b1, 9'd64, 8'd57, 3'b110, 1'b1}) begin
            miscompares++;
            $display("FAIL first_draw_req: got start=%b (%0d,%0d) col=%b busy=%b, want 1 (64,57) 110 1",
                     oStart, oX, oY, oColour, oBusy);
        end
        repeat (3) tick();
        vectors++;
        if ({oStart, oX, oY, oBusy} !== {1'b0, 9'd64, 8'd57, 1'b1}) begin
            miscompares++;
            $display("FAIL first_draw_hold: got start=%b (%0d,%0d) busy=%b, want 0 (64,57) 1", oStart, oX, oY, oBusy);
        end
        pulse_done();
        vectors++;
        if ({oActiveNote, oActiveValid, oBusy} !== {4'd4, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL first_draw_done: got note=%0d valid=%b busy=%b, want 4 1 0", oActiveNote, oActiveValid, oBusy);
        end
    endtask

    task automatic test_glitch();
        bit seen = 1'b0;
        iNote = 4'd7;
        repeat (10) tick();
        iNote = 4'd4;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (oStart === 1'b1 || oBusy === 1'b1) seen = 1'b1;
        end
        vectors++;
        if ({seen, oActiveNote, oActiveValid} !== {1'b0, 4'd4, 1'b1}) begin
            miscompares++;
            $display("FAIL glitch: got activity=%b note=%0d valid=%b, want 0 4 1", seen, oActiveNote, oActiveValid);
        end
    endtask

    // Erase of the shown note followed by a draw of the new one.
    task automatic test_change_note(input logic [3:0] nxt,
                                    input logic [8:0] ex, input logic [7:0] ey, input logic [2:0] ec,
                                    input logic [8:0] dx, input logic [7:0] dy);
        int n;
        iNote = nxt;
        wait_start(40, n);
        vectors++;
        if (n !== REQ_TICKS || {oX, oY, oColour} !== {ex, ey, ec}) begin
            miscompares++;
            $display("FAIL change_erase_req(%0d): got edges=%0d (%0d,%0d) col=%b, want %0d (%0d,%0d) %b",
                     nxt, n, oX, oY, oColour, REQ_TICKS, ex, ey, ec);
        end
        tick();
        pulse_done();
        vectors++;
        if ({oStart, oActiveValid, oX, oY, oColour} !== {1'b1, 1'b0, dx, dy, 3'b110}) begin
            miscompares++;
            $display("FAIL change_draw_req(%0d): got start=%b valid=%b (%0d,%0d) col=%b, want 1 0 (%0d,%0d) 110",
                     nxt, oStart, oActiveValid, oX, oY, oColour, dx, dy);
        end
        tick();
        pulse_done();
        vectors++;
        if ({oActiveNote, oActiveValid, oBusy} !== {nxt, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL change_done(%0d): got note=%0d valid=%b busy=%b, want %0d 1 0",
                     nxt, oActiveNote, oActiveValid, oBusy, nxt);
        end
    endtask

    task automatic test_note_off();
        int n;
        bit seen = 1'b0;
        iNoteOn = 1'b0;
        wait_start(40, n);
        vectors++;
        if (n !== REQ_TICKS || {oX, oY, oColour} !== {9'd57, 8'd44, 3'b000}) begin
            miscompares++;
            $display("FAIL off_erase_req: got edges=%0d (%0d,%0d) col=%b, want %0d (57,44) 000",
                     n, oX, oY, oColour, REQ_TICKS);
        end
        tick();
        pulse_done();
        for (int i = 0; i < 20; i++) begin
            if (oStart === 1'b1 || oBusy === 1'b1) seen = 1'b1;
            tick();
        end
        vectors++;
        if ({seen, oActiveValid} !== 2'b00) begin
            miscompares++;
            $display("FAIL off_no_draw: got activity=%b valid=%b, want 0 0", seen, oActiveValid);
        end
    endtask

    task automatic test_timeout();
        int n;
        iNoteOn = 1'b1; iNote = 4'd5;
        wait_start(40, n);
        vectors++;
        if (n !== REQ_TICKS || {oX, oY, oColour} !== {9'd80, 8'd57, 3'b110}) begin
            miscompares++;
            $display("FAIL to_draw_req: got edges=%0d (%0d,%0d) col=%b, want %0d (80,57) 110",
                     n, oX, oY, oColour, REQ_TICKS);
        end
        repeat (1024) tick();
        vectors++;
        if ({oTimeout, oBusy} !== 2'b01) begin
            miscompares++;
            $display("FAIL to_not_yet: got timeout=%b busy=%b, want 0 1", oTimeout, oBusy);
        end
        tick();
        vectors++;
        if ({oTimeout, oBusy, oActiveValid} !== 3'b100) begin
            miscompares++;
            $display("FAIL to_expired: got timeout=%b busy=%b valid=%b, want 1 0 0", oTimeout, oBusy, oActiveValid);
        end
        tick();
        vectors++;
        if ({oStart, oX, oY} !== {1'b1, 9'd80, 8'd57}) begin
            miscompares++;
            $display("FAIL to_retry: got start=%b (%0d,%0d), want 1 (80,57)", oStart, oX, oY);
        end
        tick();
        pulse_done();
        vectors++;
        if ({oActiveNote, oActiveValid, oTimeout} !== {4'd5, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL to_recover: got note=%0d valid=%b timeout=%b, want 5 1 1", oActiveNote, oActiveValid, oTimeout);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        iNote = 4'd2;
        wait_start(40, n);
        tick();
        pulse_done();
        vectors++;
        if ({oStart, oX, oY, oColour} !== {1'b1, 9'd49, 8'd57, 3'b110}) begin
            miscompares++;
            $display("FAIL b2b_draw2: got start=%b (%0d,%0d) col=%b, want 1 (49,57) 110", oStart, oX, oY, oColour);
        end
        iNote = 4'd9;
        repeat (20) tick();
        vectors++;
        if ({oStart, oBusy, oX, oActiveValid} !== {1'b0, 1'b1, 9'd49, 1'b0}) begin
            miscompares++;
            $display("FAIL b2b_wait_hold: got start=%b busy=%b x=%0d valid=%b, want 0 1 49 0", oStart, oBusy, oX, oActiveValid);
        end
        pulse_done();
        vectors++;
        if ({oActiveNote, oActiveValid} !== {4'd2, 1'b1}) begin
            miscompares++;
            $display("FAIL b2b_shown2: got note=%0d valid=%b, want 2 1", oActiveNote, oActiveValid);
        end
        tick();
        vectors++;
        if ({oStart, oX, oY, oColour} !== {1'b1, 9'd49, 8'd57, 3'b111}) begin
            miscompares++;
            $display("FAIL b2b_erase2: got start=%b (%0d,%0d) col=%b, want 1 (49,57) 111", oStart, oX, oY, oColour);
        end
        tick();
        pulse_done();
        vectors++;
        if ({oStart, oX, oY, oColour} !== {1'b1, 9'd112, 8'd57, 3'b110}) begin
            miscompares++;
            $display("FAIL b2b_draw9: got start=%b (%0d,%0d) col=%b, want 1 (112,57) 110", oStart, oX, oY, oColour);
        end
        tick();
        pulse_done();
        vectors++;
        if ({oActiveNote, oActiveValid} !== {4'd9, 1'b1}) begin
            miscompares++;
            $display("FAIL b2b_shown9: got note=%0d valid=%b, want 9 1", oActiveNote, oActiveValid);
        end
        iNote = 4'd13;
        wait_start(40, n);
        vectors++;
        if (n !== REQ_TICKS || {oX, oY, oColour} !== {9'd112, 8'd57, 3'b111}) begin
            miscompares++;
            $display("FAIL b2b_note13_erase: got edges=%0d (%0d,%0d) col=%b, want %0d (112,57) 111",
                     n, oX, oY, oColour, REQ_TICKS);
        end
        tick();
        pulse_done();
        tick();
        vectors++;
        if ({oStart, oBusy, oActiveValid} !== 3'b000) begin
            miscompares++;
            $display("FAIL b2b_note13_idle: got start=%b busy=%b valid=%b, want 000", oStart, oBusy, oActiveValid);
        end
    endtask

    initial begin
        test_reset();
        test_first_draw();
        test_glitch();
        test_change_note(4'd1, 9'd64, 8'd57, 3'b111, 9'd40, 8'd44);
        test_change_note(4'd3, 9'd40, 8'd44, 3'b000, 9'd57, 8'd44);
        test_note_off();
        test_timeout();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
